// File: rtl/fsm_serial_pkg.sv
// Shared definitions for the single-bit serial frame protocol.
// The transmitter and receiver FSMs both import this package.
package fsm_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    STOP   = 3'd3,
    BREAK  = 3'd4
  } state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam int   MAX_W     = 16;

  // Callers pass narrower words zero-extended; the zero bits do not change the XOR.
  function automatic logic par_calc(input logic [MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fsm_serial_shift_cnt.sv
// Receive shift register and bit counter for the serial frame receiver.
// load clears both; shift takes one LSB-first bit; otherwise both hold.
module fsm_serial_shift_cnt #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] word_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic [DATA_W-1:0] word_q;
  logic [CNT_W-1:0]  cnt_q;

  // Shifting in from the MSB end leaves the first bit at bit 0 after DATA_W shifts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (shift_i) begin
      word_q <= {bit_i, word_q[DATA_W-1:1]};
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign word_o = word_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/fsm_serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W bits LSB first, optional parity, stop.
// Presents each good word with a one-cycle data_valid; bad stop pulses frame_err.
module fsm_serial_frame_rx
  import fsm_serial_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_in,
  input  logic              rx_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              parity_err_q;
  logic              frame_err_q;
  logic              par_q;

  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt;
  logic              load_d;
  logic              shift_d;
  logic              par_exp;

  assign load_d  = rx_en && (state_q == IDLE) && (rx_in != LINE_IDLE);
  assign shift_d = rx_en && (state_q == DATA);
  assign par_exp = par_calc(MAX_W'(word), 1'(ODD_PARITY));

  fsm_serial_shift_cnt #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shift_cnt (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_d),
    .shift_i (shift_d),
    .bit_i   (rx_in),
    .word_o  (word),
    .cnt_o   (cnt)
  );

  // Pulses default low every cycle so each lasts exactly one clock, even with rx_en low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      par_q        <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (rx_en) begin
        case (state_q)
          IDLE: begin
            if (rx_in != LINE_IDLE) state_q <= DATA;
          end
          DATA: begin
            if (cnt == LAST_BIT) state_q <= (PARITY_EN != 0) ? PARITY : STOP;
          end
          PARITY: begin
            par_q   <= rx_in;
            state_q <= STOP;
          end
          STOP: begin
            if (rx_in == LINE_IDLE) begin
              data_out_q   <= word;
              data_valid_q <= 1'b1;
              parity_err_q <= (PARITY_EN != 0) && (par_q != par_exp);
              state_q      <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end
          BREAK: begin
            // A low line here is the tail of a broken frame, never a new start bit.
            if (rx_in == LINE_IDLE) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/fsm_serial_frame_rx.md
Name: fsm_serial_frame_rx

Overview:
- Serial frame receiver FSM; the receiving end of the team's single-bit, one-bit-per-enabled-clock serial frame protocol.
- Samples a 1-bit line, detects a start bit, and shifts in DATA_W bits LSB first.
- Checks optional parity and the stop bit, then presents the parallel word with a one-cycle valid strobe.
- Sits between the serial line (driven by the matching transmitter FSM) and parallel consumer logic.

Parameters:
- DATA_W, 8, number of data bits per frame (2..16).
- PARITY_EN, 1, 1 = a parity bit follows the data; 0 = no parity bit.
- ODD_PARITY, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_in  input  1  serial line; idle level 1.
- rx_en  input  1  bit-slot strobe; rx_in is sampled only on cycles with rx_en=1.
- data_out  output  DATA_W  last received word; holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse when data_out is updated.
- parity_err  output  1  one-cycle pulse with data_valid when parity mismatches.
- frame_err  output  1  one-cycle pulse when the stop bit is 0.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset: clock: clk; reset: reset, asynchronous, active-high.
  - Asserting reset forces state IDLE and clears the shift register and bit counter.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Reset mid-frame aborts the frame; no valid or error pulse is generated for it.
- States: IDLE, DATA, PARITY, STOP, BREAK. All transitions occur only on cycles with rx_en=1, except the pulse clearing described below.
- IDLE: rx_in=0 moves to DATA with bit counter=0; rx_in=1 stays in IDLE.
- DATA:
  - Shift rx_in into bit position counter (LSB first); increment the counter.
  - After the DATA_W-th bit, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: capture rx_in as the received parity bit; go to STOP.
- Parity expected value:
  - Expected bit = XOR of the data bits when ODD_PARITY=0.
  - Expected bit = inverted XOR of the data bits when ODD_PARITY=1.
- STOP with rx_in=1 (good stop):
  - Next cycle: data_out <= shifted word, data_valid=1.
  - parity_err=1 if PARITY_EN=1 and the received parity bit differs from the expected bit.
  - Return to IDLE.
- STOP with rx_in=0 (bad stop):
  - Next cycle: frame_err=1, data_valid=0, data_out unchanged.
  - Go to BREAK.
- BREAK: remain until a sampled rx_in=1, then go to IDLE. A low line after a bad stop is never taken as a new start bit.
- Latency: data_valid rises in the clock cycle after the rising edge that samples the stop bit, independent of rx_en.
- Pulse timing:
  - All pulse outputs are registered and last exactly one cycle.
  - They are cleared on the following cycle regardless of rx_en.
- rx_en=0 in any state: state, counter and shift register hold; the sample is ignored.
- Back-to-back frames: a start bit sampled in the first enabled slot after the stop bit is accepted. data_valid for frame N may coincide with the start-bit sample of frame N+1.
- Glitch rule: no oversampling and no start-bit revalidation. Each enabled sample is one bit.
- Bit counter width: clog2(DATA_W)+1 bits; it must not wrap within a frame.

Decomposition:
- Shared package fsm_serial_pkg:
  - state enum (IDLE, DATA, PARITY, STOP, BREAK) with a 3-bit encoding;
  - idle-level constant LINE_IDLE=1;
  - parity-compute function par_calc(data, odd).
- The matching transmitter uses the same package.
- One natural sub-module: fsm_serial_shift_cnt, the shift register plus bit counter with load, shift and hold controls.
- The FSM, parity check and output registers stay in the top module.

Test Plan:
- DATA_W=8, even parity, rx_en=1 continuously, line sends 0,1,0,1,0,0,1,0,1,0,1 (start, 0xA5 LSB first, parity 0, stop) -> data_out=0xA5 with data_valid=1 one cycle after the stop sample; parity_err=0, frame_err=0.
- Same frame with parity bit 1 -> data_out=0xA5, data_valid=1 and parity_err=1 in the same cycle.
- Frame 0x3C with stop bit 0, then line held 0 for 4 enabled cycles, then 1 -> frame_err=1 for one cycle, data_out keeps its previous value, busy stays high through BREAK, returns to IDLE only after the 1; no false start.
- rx_en toggling 1,0,1,0 during the frame for 0x81 -> data_out=0x81; every frame bit is sampled only on rx_en=1 cycles (the rx_en=0 cycles between them add no bits); data_valid one cycle after the enabled stop sample.
- Two back-to-back frames 0x12 then 0xFE with no idle gap -> two data_valid pulses with the correct values; the second start bit is accepted directly after the first stop.
- Reset asserted asynchronously after the 4th data bit -> all outputs 0 immediately. With reset released and the line idle, no data_valid or frame_err pulse occurs; the next full frame 0x55 is received correctly.
